// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control and data in, register state and flag out.
// The register drives Q/NQ/CO; whoever owns the register drives the rest.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8
);
   logic             EN;
   logic [2:0]       MODE;
   logic [WIDTH-1:0] D;
   logic             SL;
   logic             SR;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] NQ;
   logic             CO;

   modport master (
      output EN, MODE, D, SL, SR,
      input  Q, NQ, CO
   );

   modport slave (
      input  EN, MODE, D, SL, SR,
      output Q, NQ, CO
   );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate, up/down count with a
// one-cycle carry/borrow pulse. Priority per edge is RST, then EN, then MODE.
module universal_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic                 CP,
   input logic                 RST,
   universal_shift_reg_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;
   logic             co_r;
   logic [WIDTH-1:0] q_s;
   logic             co_s;

   // Next-state selection for an enabled edge; the flag only rises on a wrap.
   always_comb begin
      q_s  = q_r;
      co_s = 1'b0;
      case (bus.MODE)
         3'b000: q_s = q_r;
         3'b001: q_s = bus.D;
         3'b010: q_s = {q_r[WIDTH-2:0], bus.SL};
         3'b011: q_s = {bus.SR, q_r[WIDTH-1:1]};
         3'b100: q_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
         3'b101: q_s = {q_r[0], q_r[WIDTH-1:1]};
         3'b110: begin
            q_s  = q_r + ONE;
            co_s = &q_r;
         end
         3'b111: begin
            q_s  = q_r - ONE;
            co_s = ~|q_r;
         end
         default: begin
            q_s  = q_r;
            co_s = 1'b0;
         end
      endcase
   end

   // State register; a disabled edge freezes Q but still clears the flag.
   always_ff @(posedge CP) begin
      if (RST) begin
         q_r  <= RESET_VAL;
         co_r <= 1'b0;
      end else if (bus.EN) begin
         q_r  <= q_s;
         co_r <= co_s;
      end else begin
         q_r  <= q_r;
         co_r <= 1'b0;
      end
   end

   assign bus.Q  = q_r;
   assign bus.NQ = ~q_r;
   assign bus.CO = co_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8 (reset 0)
// and WIDTH=4 (reset 9), with hand-computed expected values.
module tb_universal_shift_reg;

   logic cp;
   logic rst8;
   logic rst4;
   int   checks;
   int   failures;

   universal_shift_reg_if #(.WIDTH(8)) bus8();
   universal_shift_reg_if #(.WIDTH(4)) bus4();

   universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
      .CP  (cp),
      .RST (rst8),
      .bus (bus8)
   );

   universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'h9)) dut4 (
      .CP  (cp),
      .RST (rst4),
      .bus (bus4)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic step();
      @(posedge cp);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive8(input logic en, input logic [2:0] mode, input logic [7:0] d,
                         input logic sl, input logic sr);
      bus8.EN   = en;
      bus8.MODE = mode;
      bus8.D    = d;
      bus8.SL   = sl;
      bus8.SR   = sr;
   endtask

   task automatic expect8(input string tag, input logic [7:0] q, input logic co);
      chk({tag, "_q"}, bus8.Q, q);
      chk({tag, "_nq"}, bus8.NQ, ~q);
      chk({tag, "_co"}, {7'd0, bus8.CO}, {7'd0, co});
   endtask

   task automatic expect4(input string tag, input logic [3:0] q, input logic co);
      chk({tag, "_q"}, {4'h0, bus4.Q}, {4'h0, q});
      chk({tag, "_nq"}, {4'h0, bus4.NQ}, {4'h0, ~q});
      chk({tag, "_co"}, {7'd0, bus4.CO}, {7'd0, co});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst8     = 1'b1;
      rst4     = 1'b1;
      drive8(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
      bus4.EN   = 1'b1;
      bus4.MODE = 3'b001;
      bus4.D    = 4'h3;
      bus4.SL   = 1'b0;
      bus4.SR   = 1'b0;

      // 1: reset dominates load, then released reset loads
      step();
      expect8("rst_e1", 8'h00, 1'b0);
      step();
      expect8("rst_e2", 8'h00, 1'b0);
      rst8 = 1'b0;
      step();
      expect8("rel_load", 8'hA5, 1'b0);

      // 2: shifts with serial inputs
      drive8(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
      step();
      expect8("load81", 8'h81, 1'b0);
      drive8(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      step();
      expect8("shl_sl1", 8'h03, 1'b0);
      drive8(1'b1, 3'b010, 8'hFF, 1'b0, 1'b1);
      step();
      expect8("shl_sl0", 8'h06, 1'b0);
      drive8(1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
      step();
      expect8("shr_sr1", 8'h83, 1'b0);
      drive8(1'b1, 3'b011, 8'hFF, 1'b1, 1'b0);
      step();
      expect8("shr_sr0", 8'h41, 1'b0);

      // 3: rotates
      drive8(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
      step();
      drive8(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      step();
      expect8("rotl", 8'h03, 1'b0);
      drive8(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
      step();
      drive8(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      step();
      expect8("rotr", 8'hC0, 1'b0);
      for (int i = 0; i < 8; i++) step();
      expect8("rotr_x8", 8'hC0, 1'b0);

      // 4: counter wrap both directions
      drive8(1'b1, 3'b001, 8'hFE, 1'b0, 1'b0);
      step();
      drive8(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      step();
      expect8("inc_ff", 8'hFF, 1'b0);
      step();
      expect8("inc_wrap", 8'h00, 1'b1);
      step();
      expect8("inc_01", 8'h01, 1'b0);
      drive8(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
      step();
      expect8("load00", 8'h00, 1'b0);
      drive8(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
      step();
      expect8("dec_wrap", 8'hFF, 1'b1);
      step();
      expect8("dec_fe", 8'hFE, 1'b0);

      // 5: enable and reset priority
      drive8(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
      step();
      drive8(1'b0, 3'b110, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect8("en0_hold", 8'hFF, 1'b0);
      end
      rst8 = 1'b1;
      step();
      expect8("rst_en0", 8'h00, 1'b0);
      rst8 = 1'b0;
      drive8(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
      step();
      expect8("reload_ff", 8'hFF, 1'b0);
      drive8(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      rst8 = 1'b1;
      step();
      expect8("rst_on_wrap", 8'h00, 1'b0);
      rst8 = 1'b0;
      drive8(1'b0, 3'b000, 8'h00, 1'b0, 1'b0);

      // 6: narrow instance with non-zero reset value
      expect4("w4_rst", 4'h9, 1'b0);
      rst4      = 1'b0;
      bus4.MODE = 3'b110;
      step();
      expect4("w4_a", 4'hA, 1'b0);
      step();
      expect4("w4_b", 4'hB, 1'b0);
      step();
      expect4("w4_c", 4'hC, 1'b0);
      step();
      expect4("w4_d", 4'hD, 1'b0);
      step();
      expect4("w4_e", 4'hE, 1'b0);
      step();
      expect4("w4_f", 4'hF, 1'b0);
      step();
      expect4("w4_wrap", 4'h0, 1'b1);
      bus4.MODE = 3'b010;
      bus4.SL   = 1'b1;
      step();
      expect4("w4_shl", 4'h1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
